// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions for the broadcast (fan-out) and majority-vote join blocks.
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int NUM_LANES       = 3;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/axis_pkt_counter.sv
// Free-running completed-packet counter: counts tlast beats, wraps modulo 2^CNT_WIDTH.
module axis_pkt_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  // Count register, wraps naturally on overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_WIDTH{1'b0}};
    end else if (i_inc) begin
      r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/axis_broadcast_3.sv
// Lossless 1-to-3 AXI-Stream fan-out with a single shared holding register and
// a per-packet lane enable mask sampled at the first beat of each packet.
module axis_broadcast_3
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_0,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_1,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_2,
  output logic                  m_axis_tvalid_0,
  output logic                  m_axis_tvalid_1,
  output logic                  m_axis_tvalid_2,
  input  logic                  m_axis_tready_0,
  input  logic                  m_axis_tready_1,
  input  logic                  m_axis_tready_2,
  output logic                  m_axis_tlast_0,
  output logic                  m_axis_tlast_1,
  output logic                  m_axis_tlast_2,
  input  logic [2:0]            cfg_out_en,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [NUM_LANES-1:0]  r_pend;
  logic [NUM_LANES-1:0]  r_mask;
  pkt_state_e            r_state;
  pkt_state_e            w_state_nxt;
  logic [NUM_LANES-1:0]  w_lane_rdy;
  logic [NUM_LANES-1:0]  w_act_mask;
  logic                  w_ready;
  logic                  w_accept;

  assign w_lane_rdy = {m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};
  // Ready when every still-pending lane completes this cycle: full rate with no bubble
  assign w_ready    = ((r_pend & ~w_lane_rdy) == 3'b000);
  assign w_accept   = s_axis_tvalid & w_ready;

  // Packet state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and active lane mask (live cfg at packet start, latched mask inside a packet)
  always_comb begin
    w_state_nxt = r_state;
    w_act_mask  = r_mask;
    case (r_state)
      IDLE: begin
        w_act_mask = cfg_out_en;
        if (w_accept && !s_axis_tlast) begin
          w_state_nxt = PKT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PKT: begin
        w_act_mask = r_mask;
        if (w_accept && s_axis_tlast) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = PKT;
        end
      end
      default: begin
        w_act_mask  = 3'b000;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Holding register: a new load overrides any lane completing on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {DATA_WIDTH{1'b0}};
      r_last <= 1'b0;
      r_pend <= 3'b000;
    end else if (w_accept) begin
      r_data <= s_axis_tdata;
      r_last <= s_axis_tlast;
      r_pend <= w_act_mask;
    end else begin
      r_data <= r_data;
      r_last <= r_last;
      r_pend <= r_pend & ~w_lane_rdy;
    end
  end

  // Lane mask latch at the first beat of a packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= 3'b000;
    end else if (w_accept && (r_state == IDLE)) begin
      r_mask <= cfg_out_en;
    end else begin
      r_mask <= r_mask;
    end
  end

  axis_pkt_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_pkt_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_accept & s_axis_tlast),
    .o_count (pkt_count)
  );

  assign s_axis_tready   = w_ready;
  assign m_axis_tdata_0  = r_data;
  assign m_axis_tdata_1  = r_data;
  assign m_axis_tdata_2  = r_data;
  assign m_axis_tlast_0  = r_last;
  assign m_axis_tlast_1  = r_last;
  assign m_axis_tlast_2  = r_last;
  assign m_axis_tvalid_0 = r_pend[0];
  assign m_axis_tvalid_1 = r_pend[1];
  assign m_axis_tvalid_2 = r_pend[2];
  assign busy            = (r_pend != 3'b000) || (r_state == PKT);

endmodule

// File: tb/tb_axis_broadcast_3.sv
// Directed bench for axis_broadcast_3 with a per-lane expected-beat scoreboard.
module tb_axis_broadcast_3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata_0, m_tdata_1, m_tdata_2;
  logic        m_tvalid_0, m_tvalid_1, m_tvalid_2;
  logic        m_tready_0, m_tready_1, m_tready_2;
  logic        m_tlast_0, m_tlast_1, m_tlast_2;
  logic [2:0]  cfg;
  logic [15:0] pkt_count;
  logic        busy;

  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;
  int          last_wait  = 0;
  logic        chk_lat    = 1'b0;
  logic [2:0]  forbid     = 3'b000;
  logic        in_pkt     = 1'b0;
  logic [2:0]  model_mask = 3'b000;
  logic [15:0] exp_pkt    = 16'd0;
  logic [64:0] q0[$];
  logic [64:0] q1[$];
  logic [64:0] q2[$];

  axis_broadcast_3 #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata_0(m_tdata_0), .m_axis_tdata_1(m_tdata_1), .m_axis_tdata_2(m_tdata_2),
    .m_axis_tvalid_0(m_tvalid_0), .m_axis_tvalid_1(m_tvalid_1), .m_axis_tvalid_2(m_tvalid_2),
    .m_axis_tready_0(m_tready_0), .m_axis_tready_1(m_tready_1), .m_axis_tready_2(m_tready_2),
    .m_axis_tlast_0(m_tlast_0), .m_axis_tlast_1(m_tlast_1), .m_axis_tlast_2(m_tlast_2),
    .cfg_out_en(cfg), .pkt_count(pkt_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lane_pop(input int i, input logic [32:0] obs);
    logic [64:0] e;
    int sz;
    case (i)
      0: sz = q0.size();
      1: sz = q1.size();
      2: sz = q2.size();
      default: sz = 0;
    endcase
    chk($sformatf("lane%0d_unexpected_beat", i), (sz == 0) ? 64'd1 : 64'd0, 64'd0);
    if (sz != 0) begin
      case (i)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("lane%0d_beat", i), {31'd0, obs}, {31'd0, e[32:0]});
      if (chk_lat) chk($sformatf("lane%0d_latency", i), cyc, e[64:33] + 32'd1);
    end
  endtask

  // Monitor and reference model, sampled on the falling edge
  initial begin
    logic [2:0]  act;
    logic [64:0] ent;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (m_tvalid_0 && m_tready_0) lane_pop(0, {m_tlast_0, m_tdata_0});
        if (m_tvalid_1 && m_tready_1) lane_pop(1, {m_tlast_1, m_tdata_1});
        if (m_tvalid_2 && m_tready_2) lane_pop(2, {m_tlast_2, m_tdata_2});
        if (forbid != 3'b000)
          chk("forbidden_lane_valid", {61'd0, {m_tvalid_2, m_tvalid_1, m_tvalid_0} & forbid}, 64'd0);
        if (s_tvalid && s_tready) begin
          act = in_pkt ? model_mask : cfg;
          if (!in_pkt) model_mask = cfg;
          ent = {cyc[31:0], s_tlast, s_tdata};
          if (act[0]) q0.push_back(ent);
          if (act[1]) q1.push_back(ent);
          if (act[2]) q2.push_back(ent);
          if (s_tlast) begin
            exp_pkt = exp_pkt + 16'd1;
            in_pkt  = 1'b0;
          end else begin
            in_pkt  = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 50) begin
      n++;
      @(negedge clk);
    end
    last_wait = n;
    chk("send_timeout", (n >= 50) ? 64'd1 : 64'd0, 64'd0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s_tdata = 32'd0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready_0 = 1'b1; m_tready_1 = 1'b1; m_tready_2 = 1'b1; cfg = 3'b111;
    #3;
    chk("rst_valids", {61'd0, m_tvalid_2, m_tvalid_1, m_tvalid_0}, 64'd0);
    chk("rst_tready", {63'd0, s_tready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // 1: full-rate 4-beat packet on all lanes
    chk_lat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'hA0 + i, (i == 3) ? 1'b1 : 1'b0);
      chk("t1_tready_no_stall", last_wait, 64'd0);
    end
    idle(3);
    chk_lat = 1'b0;
    chk("t1_pkt_count", {48'd0, pkt_count}, 64'd1);
    chk("t1_busy_idle", {63'd0, busy}, 64'd0);

    // 2: lane 1 stalls for 5 cycles on 0x55
    m_tready_1 = 1'b0;
    send(32'h55, 1'b0);
    s_tdata = 32'h56; s_tlast = 1'b1; s_tvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_tready_low", {63'd0, s_tready}, 64'd0);
      chk("t2_lane1_valid", {63'd0, m_tvalid_1}, 64'd1);
      chk("t2_data_held", {32'd0, m_tdata_1}, 64'h55);
      if (k > 0) chk("t2_lane02_done", {62'd0, m_tvalid_2, m_tvalid_0}, 64'd0);
    end
    @(posedge clk); #1;
    m_tready_1 = 1'b1;
    send(32'h56, 1'b1);
    idle(3);
    chk("t2_pkt_count", {48'd0, pkt_count}, 64'd2);

    // 3: mask 101 latched at packet start, cfg change mid-packet ignored
    forbid = 3'b010;
    cfg = 3'b101;
    send(32'h30, 1'b0);
    cfg = 3'b111;
    send(32'h31, 1'b0);
    send(32'h32, 1'b1);
    idle(3);
    forbid = 3'b000;
    send(32'h40, 1'b0);
    send(32'h41, 1'b1);
    idle(3);

    // 4: zero mask sinks beats at full rate
    forbid = 3'b111;
    cfg = 3'b000;
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) begin
        send(32'hC0 + 3 * p + b, (b == 2) ? 1'b1 : 1'b0);
        chk("t4_sink_rate", last_wait, 64'd0);
      end
    end
    idle(2);
    chk("t4_pkt_count", {48'd0, pkt_count}, 64'd6);
    chk("t4_pkt_model", {48'd0, pkt_count}, {48'd0, exp_pkt});

    // 5: counter wrap
    begin
      int n_pre;
      n_pre = 65535 - int'(exp_pkt);
      for (int i = 0; i < n_pre; i++) send(i, 1'b1);
    end
    idle(1);
    chk("t5_count_max", {48'd0, pkt_count}, 64'hFFFF);
    send(32'hEE, 1'b1);
    idle(1);
    chk("t5_count_wrap", {48'd0, pkt_count}, 64'd0);
    forbid = 3'b000;

    // 6: reset while lanes 0 and 2 are pending mid-packet
    cfg = 3'b101;
    m_tready_0 = 1'b0; m_tready_2 = 1'b0;
    send(32'h60, 1'b0);
    @(negedge clk);
    chk("t6_pending", {61'd0, m_tvalid_2, m_tvalid_1, m_tvalid_0}, 64'd5);
    chk("t6_busy_before", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    in_pkt = 1'b0; exp_pkt = 16'd0;
    #1;
    chk("t6_rst_valids", {61'd0, m_tvalid_2, m_tvalid_1, m_tvalid_0}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_tready", {63'd0, s_tready}, 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    m_tready_0 = 1'b1; m_tready_2 = 1'b1;
    cfg = 3'b010;
    forbid = 3'b101;
    send(32'h70, 1'b1);
    idle(3);
    forbid = 3'b000;
    chk("t6_pkt_count", {48'd0, pkt_count}, 64'd1);
    chk("t6_busy_end", {63'd0, busy}, 64'd0);

    chk("lane0_drained", q0.size(), 64'd0);
    chk("lane1_drained", q1.size(), 64'd0);
    chk("lane2_drained", q2.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_broadcast_3.md
Name: axis_broadcast_3

Overview:
- Fans one AXI-Stream input out to three identical AXI-Stream outputs, one per classifier lane, in front of the three classifiers.
- Each output handshakes independently. A beat is released upstream only after every enabled output has taken it, so the three lanes always see identical, lossless streams.
- Per-packet output enable mask lets software disable a lane without stalling the others.
- Provides a completed-packet counter for bring-up.

Parameters:
- DATA_WIDTH, 32, width of tdata on input and all outputs.
- CNT_WIDTH, 16, width of pkt_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  DATA_WIDTH  input beat data
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of packet
- m_axis_tdata_0/1/2  out  DATA_WIDTH  lane i data
- m_axis_tvalid_0/1/2  out  1  lane i valid
- m_axis_tready_0/1/2  in  1  lane i ready
- m_axis_tlast_0/1/2  out  1  lane i last
- cfg_out_en  in  3  lane enable mask; bit i = lane i; sampled only at the first beat of a packet
- pkt_count  out  CNT_WIDTH  packets fully accepted at the input (tlast beats)
- busy  out  1  high while any lane has an undelivered beat or a packet is open

Behaviour:
Storage:
- One shared holding register: data_q, last_q, pend_q[2:0].
- m_axis_tdata_i = data_q and m_axis_tlast_i = last_q for all lanes.
- m_axis_tvalid_i = pend_q[i].

Reset values:
- pend_q = 0, so all m_axis_tvalid_i = 0.
- data_q = 0, last_q = 0, mask_q = 0, pkt_count = 0, state = IDLE.
- s_axis_tready = 1 and busy = 0.

Lane drain:
- pend_q[i] clears on any cycle where m_axis_tvalid_i && m_axis_tready_i.
- Lanes drain in any order and at any time. Data is held stable while pend_q[i] = 1.

Input ready:
- s_axis_tready = ((pend_q & ~{m_axis_tready_2, m_axis_tready_1, m_axis_tready_0}) == 3'b000).
- In words: ready when nothing is pending, or every pending lane completes this cycle.
- This is a combinational path from the m_axis_tready inputs. It gives full throughput of 1 beat/cycle when all enabled lanes are ready.

Accept (s_axis_tvalid && s_axis_tready):
- data_q <= s_axis_tdata, last_q <= s_axis_tlast, pend_q <= active mask.
- Latency from input accept to m_axis_tvalid_i is 1 cycle.

Packet FSM:
- IDLE (at packet boundary):
  - Active mask = cfg_out_en; mask_q <= cfg_out_en on accept.
  - Accept with tlast=0 -> PKT.
  - Accept with tlast=1 -> stay IDLE (single-beat packet).
- PKT:
  - Active mask = mask_q. Changes on cfg_out_en are ignored.
  - Accept with tlast=1 -> IDLE.

Zero mask:
- If the active mask is 000, beats are accepted and discarded (sink mode).
- pend_q stays 0, no output valid, pkt_count still counts.

Packet counter:
- pkt_count increments by 1 on each accepted beat with s_axis_tlast = 1.
- Wraps modulo 2^CNT_WIDTH, no saturation.

Busy:
- busy = (pend_q != 0) || (state == PKT).

Simultaneous events:
- Drain of the last pending lane and a new input accept in the same cycle: the new beat loads and pend_q takes the new mask. No bubble, no duplicate.
- A lane that completes in the same cycle as the new load is not re-counted for the old beat.

Reset mid-operation:
- Asynchronous reset drops all valids immediately.
- Pending beats and the open packet are discarded. FSM returns to IDLE.

Protocol assumptions on upstream:
- s_axis_tdata and s_axis_tlast are stable while s_axis_tvalid is high and not accepted.
- The block never asserts m_axis_tvalid_i without a pending beat.

Decomposition:
- Shared package axis_pkg: AXIS_DATA_WIDTH default (32), NUM_LANES = 3, and the packet-state enum {IDLE, PKT} shared with the majority-vote join side.
- No sub-module needed; the single holding stage is inline.
- Optional reuse: axis_pkt_counter (tlast counter, CNT_WIDTH) as a small sub-module, also usable on the join output.

Test Plan:
1. Mask 111, all lanes ready, 4-beat packet 0xA0..0xA3 back-to-back:
   - Each lane outputs 0xA0..0xA3 on consecutive cycles, 1 cycle after input.
   - tlast on 0xA3 only; s_axis_tready stays 1; pkt_count = 1.
2. Mask 111, lane 1 tready low for 5 cycles during beat 0x55:
   - Lanes 0 and 2 take 0x55 once and drop valid.
   - s_axis_tready = 0 until lane 1 accepts; next beat appears only after.
   - No duplicates on lanes 0 and 2.
3. Mask 101 sampled at packet start, cfg_out_en switched to 111 mid-packet (3 beats):
   - m_axis_tvalid_1 never asserts for this packet.
   - The next packet is delivered on all three lanes.
4. Mask 000, 2 packets of 3 beats:
   - All 6 beats accepted at 1/cycle, no output valid, pkt_count = 2.
5. pkt_count preset by sending 65535 single-beat packets, then one more:
   - pkt_count wraps to 0.
6. Reset asserted while lanes 0 and 2 are pending mid-packet:
   - All tvalid drop during reset, busy = 0, s_axis_tready = 1.
   - The next beat is treated as a packet start and samples cfg_out_en fresh.
